iencoder: RTL and testbench
===========================

Name: iencoder

Overview:
- Inverse of the CPU instruction decoder: takes decoded RV32I fields (inst_type, funct, rd, rs1, rs2, imm) and produces the 32-bit instruction word.
- Used by the debug instruction-injection path and by self-checking benches to generate instruction streams.
- Input and output are both valid/ready handshakes, with an output FIFO of DEPTH entries.
- Illegal field combinations are dropped and counted.

Parameters:
- inst_width, 32, instruction word width (fixed at 32 for RV32I).
- imm_width, 32, immediate width.
- inst_type_width, 32, inst_type field width; values are the shared inst_type_* constants.
- reg_width, 32, register index width; only bits [4:0] are used, upper bits must be 0.
- funct_width, 32, funct field width; values are the shared funct_* constants.
- DEPTH, 2, output FIFO entries (power of two, >=2).
- ERR_CNT_WIDTH, 8, width of the error counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset: asynchronous, active-low.
- flush  in  1  synchronous FIFO clear.
- in_valid  in  1  input fields valid.
- in_ready  out  1  input accepted when in_valid && in_ready.
- in_inst_type  in  inst_type_width  instruction class.
- in_funct  in  funct_width  operation.
- in_rd  in  reg_width  destination register.
- in_rs1  in  reg_width  source register 1.
- in_rs2  in  reg_width  source register 2.
- in_imm  in  imm_width  immediate, in the decoder's convention (sign-extended byte offset; U-type carries the value already shifted).
- out_valid  out  1  out_inst valid.
- out_ready  in  1  consumer ready.
- out_inst  out  inst_width  encoded instruction, FIFO head.
- err  out  1  one-cycle pulse: the accepted input was illegal.
- err_count  out  ERR_CNT_WIDTH  saturating count of illegal inputs.

Behaviour:
- Reset (rst low, asynchronous): FIFO emptied, pointers = 0, out_valid = 0, out_inst = 0, err = 0, err_count = 0. in_ready = 0 while rst is low; in_ready = 1 on the first cycle after release.
- in_ready = !full && !flush. No full-cycle bypass: a pop in the same cycle does not open a slot for a push.
- Encoding is combinational on the input fields. An accepted legal input is written to the FIFO at that clock edge.
- Latency: accept at edge N gives out_valid high after edge N if the FIFO was empty. Order is strictly FIFO.
- Pop occurs when out_valid && out_ready. out_inst and out_valid are registered and stable while stalled.
- Simultaneous push and pop when neither full nor empty: count is unchanged and both succeed.
- Pointers wrap modulo DEPTH.
- Opcodes and formats by inst_type:
  - imm → LUI 0110111, U-type.
  - auipc → 0010111, U-type.
  - jal → 1101111, J-type.
  - jalr → 1100111, I-type, funct3 = 0.
  - int_imm → 0010011, I-type.
  - int_reg → 0110011, R-type.
  - branch → 1100011, B-type.
  - store → 0100011, S-type.
  - load → 0000011, I-type.
  - fence → constant 0x0FF0000F; all other fields ignored.
- funct3/funct7 mapping is the exact inverse of the decoder tables.
- Shifts (int_imm sll/srl/sra): shamt = imm[4:0]; funct7 = 0, or 32 for sra.
- Legality checks; any failure marks the input illegal:
  - Unknown inst_type.
  - funct not in that type's table. Examples: sub on int_imm; byteu/hwordu on store.
  - reg index > 31.
  - I/S-type: imm[31:11] not all equal.
  - Shift: imm[31:5] != 0.
  - B-type: imm[0] = 1, or imm[31:12] not all equal.
  - J-type: imm[0] = 1, or imm[31:20] not all equal.
  - U-type: imm[11:0] != 0.
- Illegal input handling: still handshaked (consumed), not written to the FIFO. err = 1 for the cycle after acceptance. err_count increments and saturates at all-ones.
- flush = 1: at the edge, FIFO is emptied and out_valid = 0. No input is accepted that cycle. err_count is unaffected. flush overrides a simultaneous pop.
- Reset mid-transfer: FIFO contents are discarded immediately; no partial words are emitted after release.

Test Plan:
- int_imm/funct_add, rd=1, rs1=0, imm=5 → out_inst 0x00500093 one cycle after accept.
- int_imm/funct_sra, rd=3, rs1=2, imm=4 → 0x40415193. int_reg/funct_sub, rd=5, rs1=6, rs2=7 → 0x407302B3.
- jal rd=1, imm=0xFFFFFFFC → 0xFFDFF0EF. branch/funct_eq rs1=1, rs2=2, imm=8 → 0x00208463. store/funct_mem_word rs1=1, rs2=2, imm=12 → 0x0020A623.
- branch imm=7, then int_reg funct_sub on int_imm type → two err pulses, err_count=2, FIFO stays empty, out_valid=0.
- out_ready=0, push 3 legal words back-to-back → in_ready drops after 2 accepts. Raise out_ready → words emerge in order, third accepted after first pop.
- FIFO holding 2 entries: pulse flush → out_valid=0 next cycle. Assert rst low mid-stream → all outputs zero immediately, err_count=0.

Source files
------------

// File: rtl/iencoder.sv
// iencoder: encode decoded RV32I fields into 32-bit instruction words behind a DEPTH-entry output FIFO
// Ports: clk/rst (async active-low), flush (sync FIFO clear); in_* fields with in_valid/in_ready;
// out_inst with out_valid/out_ready (FIFO head); err pulses the cycle after an illegal input is
// consumed; err_count is a saturating count of illegal inputs.
package iencoder_pkg;
  localparam logic [31:0] inst_type_imm = 32'd0, inst_type_auipc = 32'd1, inst_type_jal = 32'd2,
    inst_type_jalr = 32'd3, inst_type_int_imm = 32'd4, inst_type_int_reg = 32'd5,
    inst_type_branch = 32'd6, inst_type_store = 32'd7, inst_type_load = 32'd8,
    inst_type_fence = 32'd9;
  localparam logic [31:0] funct_add = 32'd0, funct_sub = 32'd1, funct_sll = 32'd2, funct_slt = 32'd3,
    funct_sltu = 32'd4, funct_xor = 32'd5, funct_srl = 32'd6, funct_sra = 32'd7, funct_or = 32'd8,
    funct_and = 32'd9, funct_eq = 32'd10, funct_ne = 32'd11, funct_lt = 32'd12, funct_ge = 32'd13,
    funct_ltu = 32'd14, funct_geu = 32'd15, funct_mem_byte = 32'd16, funct_mem_hword = 32'd17,
    funct_mem_word = 32'd18, funct_mem_byteu = 32'd19, funct_mem_hwordu = 32'd20;
endpackage

module iencoder
  import iencoder_pkg::*;
#(
  parameter int inst_width      = 32,
  parameter int imm_width       = 32,
  parameter int inst_type_width = 32,
  parameter int reg_width       = 32,
  parameter int funct_width     = 32,
  parameter int DEPTH           = 2,
  parameter int ERR_CNT_WIDTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [inst_type_width-1:0] in_inst_type,
  input  logic [funct_width-1:0]     in_funct,
  input  logic [reg_width-1:0]       in_rd,
  input  logic [reg_width-1:0]       in_rs1,
  input  logic [reg_width-1:0]       in_rs2,
  input  logic [imm_width-1:0]       in_imm,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [inst_width-1:0]      out_inst,
  output logic                       err,
  output logic [ERR_CNT_WIDTH-1:0]   err_count
);
  localparam int AW = $clog2(DEPTH);
  // Table lookups return {in_table, funct3}.
  function automatic logic [3:0] alu_f3(input logic [funct_width-1:0] f);
    case (f)
      funct_add, funct_sub: alu_f3 = 4'h8;
      funct_sll:            alu_f3 = 4'h9;
      funct_slt:            alu_f3 = 4'ha;
      funct_sltu:           alu_f3 = 4'hb;
      funct_xor:            alu_f3 = 4'hc;
      funct_srl, funct_sra: alu_f3 = 4'hd;
      funct_or:             alu_f3 = 4'he;
      funct_and:            alu_f3 = 4'hf;
      default:              alu_f3 = 4'h0;
    endcase
  endfunction
  function automatic logic [3:0] br_f3(input logic [funct_width-1:0] f);
    case (f)
      funct_eq:  br_f3 = 4'h8;
      funct_ne:  br_f3 = 4'h9;
      funct_lt:  br_f3 = 4'hc;
      funct_ge:  br_f3 = 4'hd;
      funct_ltu: br_f3 = 4'he;
      funct_geu: br_f3 = 4'hf;
      default:   br_f3 = 4'h0;
    endcase
  endfunction
  function automatic logic [3:0] mem_f3(input logic [funct_width-1:0] f);
    case (f)
      funct_mem_byte:   mem_f3 = 4'h8;
      funct_mem_hword:  mem_f3 = 4'h9;
      funct_mem_word:   mem_f3 = 4'ha;
      funct_mem_byteu:  mem_f3 = 4'hc;
      funct_mem_hwordu: mem_f3 = 4'hd;
      default:          mem_f3 = 4'h0;
    endcase
  endfunction
  logic [4:0] rd, rs1, rs2;
  logic rd_ok, rs1_ok, rs2_ok, i_ok, b_ok, j_ok, u_ok, shift, legal;
  logic [3:0] a, br, ld;
  logic [6:0] f7;
  logic [31:0] inst;
  assign rd     = in_rd[4:0];
  assign rs1    = in_rs1[4:0];
  assign rs2    = in_rs2[4:0];
  assign rd_ok  = in_rd[reg_width-1:5] == '0;
  assign rs1_ok = in_rs1[reg_width-1:5] == '0;
  assign rs2_ok = in_rs2[reg_width-1:5] == '0;
  assign i_ok   = in_imm[31:11] == {21{in_imm[31]}};
  assign b_ok   = !in_imm[0] && in_imm[31:12] == {20{in_imm[31]}};
  assign j_ok   = !in_imm[0] && in_imm[31:20] == {12{in_imm[31]}};
  assign u_ok   = in_imm[11:0] == '0;
  assign a      = alu_f3(in_funct);
  assign br     = br_f3(in_funct);
  assign ld     = mem_f3(in_funct);
  assign shift  = in_funct == funct_sll || in_funct == funct_srl || in_funct == funct_sra;
  assign f7     = (in_funct == funct_sub || in_funct == funct_sra) ? 7'h20 : 7'h00;
  always_comb begin
    inst  = '0;
    legal = 1'b0;
    case (in_inst_type)
      inst_type_imm:     begin inst = {in_imm[31:12], rd, 7'b0110111}; legal = u_ok && rd_ok; end
      inst_type_auipc:   begin inst = {in_imm[31:12], rd, 7'b0010111}; legal = u_ok && rd_ok; end
      inst_type_jal:     begin
        inst  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], rd, 7'b1101111};
        legal = j_ok && rd_ok;
      end
      inst_type_jalr:    begin
        inst  = {in_imm[11:0], rs1, 3'b000, rd, 7'b1100111};
        legal = i_ok && rd_ok && rs1_ok;
      end
      inst_type_int_imm: begin
        inst  = shift ? {f7, in_imm[4:0], rs1, a[2:0], rd, 7'b0010011}
                      : {in_imm[11:0], rs1, a[2:0], rd, 7'b0010011};
        legal = a[3] && in_funct != funct_sub && (shift ? in_imm[31:5] == '0 : i_ok) && rd_ok && rs1_ok;
      end
      inst_type_int_reg: begin
        inst  = {f7, rs2, rs1, a[2:0], rd, 7'b0110011};
        legal = a[3] && rd_ok && rs1_ok && rs2_ok;
      end
      inst_type_branch:  begin
        inst  = {in_imm[12], in_imm[10:5], rs2, rs1, br[2:0], in_imm[4:1], in_imm[11], 7'b1100011};
        legal = br[3] && b_ok && rs1_ok && rs2_ok;
      end
      // Stores have no unsigned variants, so funct3 values with bit 2 set are rejected.
      inst_type_store:   begin
        inst  = {in_imm[11:5], rs2, rs1, ld[2:0], in_imm[4:0], 7'b0100011};
        legal = ld[3] && !ld[2] && i_ok && rs1_ok && rs2_ok;
      end
      inst_type_load:    begin
        inst  = {in_imm[11:0], rs1, ld[2:0], rd, 7'b0000011};
        legal = ld[3] && i_ok && rd_ok && rs1_ok;
      end
      inst_type_fence:   begin inst = 32'h0FF0000F; legal = 1'b1; end
      default: ;
    endcase
  end
  logic [inst_width-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  logic err_q, err_d, acc, push, pop;
  logic [ERR_CNT_WIDTH-1:0] ecnt_q, ecnt_d;
  assign in_ready  = rst && !flush && cnt_q != (AW+1)'(DEPTH);
  assign acc       = in_valid && in_ready;
  assign push      = acc && legal;
  assign pop       = out_valid && out_ready && !flush;
  assign out_valid = cnt_q != '0;
  assign out_inst  = out_valid ? mem_q[rp_q] : '0;
  assign err       = err_q;
  assign err_count = ecnt_q;
  always_comb begin
    wp_d   = flush ? '0 : wp_q + AW'(push);
    rp_d   = flush ? '0 : rp_q + AW'(pop);
    cnt_d  = flush ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    err_d  = acc && !legal;
    ecnt_d = ecnt_q + ERR_CNT_WIDTH'(err_d && !(&ecnt_q));
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
      ecnt_q <= '0;
    end else begin
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      ecnt_q <= ecnt_d;
    end
  always_ff @(posedge clk)
    if (push) mem_q[wp_q] <= inst;
endmodule

// File: tb/tb_iencoder.sv
// tb_iencoder: directed and randomized checks of iencoder against a reference encoder model
module tb_iencoder;
  import iencoder_pkg::*;
  logic clk = 0, rst = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_inst_type = 0, in_funct = 0, in_rd = 0, in_rs1 = 0, in_rs2 = 0, in_imm = 0;
  logic in_ready, out_valid, err;
  logic [31:0] out_inst;
  logic [7:0] err_count;
  int cmp = 0, bad = 0;
  always #5 clk = ~clk;
  iencoder dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst_type(in_inst_type), .in_funct(in_funct), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .err(err), .err_count(err_count)
  );
  // Reference funct3 tables, -1 when the funct is not allowed for the class.
  function automatic int funct3_of(input logic [31:0] t, input logic [31:0] f);
    int alu, brn, mem;
    alu = f == funct_add ? 0 : f == funct_sub ? 0 : f == funct_sll ? 1 : f == funct_slt ? 2 :
          f == funct_sltu ? 3 : f == funct_xor ? 4 : f == funct_srl ? 5 : f == funct_sra ? 5 :
          f == funct_or ? 6 : f == funct_and ? 7 : -1;
    brn = f == funct_eq ? 0 : f == funct_ne ? 1 : f == funct_lt ? 4 : f == funct_ge ? 5 :
          f == funct_ltu ? 6 : f == funct_geu ? 7 : -1;
    mem = f == funct_mem_byte ? 0 : f == funct_mem_hword ? 1 : f == funct_mem_word ? 2 :
          f == funct_mem_byteu ? 4 : f == funct_mem_hwordu ? 5 : -1;
    if (t == inst_type_int_imm) return f == funct_sub ? -1 : alu;
    if (t == inst_type_int_reg) return alu;
    if (t == inst_type_branch) return brn;
    if (t == inst_type_load) return mem;
    if (t == inst_type_store) return mem > 2 ? -1 : mem;
    return -1;
  endfunction
  function automatic void ref_encode(input logic [31:0] t, f, d, s1, s2, im,
                                     output bit ok, output logic [31:0] w);
    int si, f3;
    bit dok, s1ok, s2ok, fit12, sh;
    logic [31:0] rdf, r1, r2, f3f, f7f;
    si = $signed(im);
    f3 = funct3_of(t, f);
    dok = d < 32; s1ok = s1 < 32; s2ok = s2 < 32;
    fit12 = si >= -2048 && si <= 2047;
    sh = f == funct_sll || f == funct_srl || f == funct_sra;
    rdf = d * 128; r1 = s1 * 32768; r2 = s2 * 32'h100000;
    f3f = (f3 < 0 ? 0 : f3) * 4096;
    f7f = (f == funct_sub || f == funct_sra) ? 32'h40000000 : 0;
    ok = 0; w = 0;
    case (t)
      inst_type_imm, inst_type_auipc: begin
        ok = dok && im % 4096 == 0;
        w = (im / 4096) * 4096 + rdf + (t == inst_type_imm ? 32'h37 : 32'h17);
      end
      inst_type_jal: begin
        ok = dok && si % 2 == 0 && si >= -1048576 && si < 1048576;
        w = 32'h6F + rdf + ((im / 4096) % 256) * 4096 + ((im / 2048) % 2) * 32'h100000 +
            ((im / 2) % 1024) * 32'h200000 + ((im / 32'h100000) % 2) * 32'h80000000;
      end
      inst_type_jalr: begin
        ok = dok && s1ok && fit12;
        w = 32'h67 + rdf + r1 + (im % 4096) * 32'h100000;
      end
      inst_type_int_imm: begin
        ok = f3 >= 0 && dok && s1ok && (sh ? im < 32 : fit12);
        w = 32'h13 + rdf + f3f + r1 + (sh ? im * 32'h100000 + f7f : (im % 4096) * 32'h100000);
      end
      inst_type_int_reg: begin
        ok = f3 >= 0 && dok && s1ok && s2ok;
        w = 32'h33 + rdf + f3f + r1 + r2 + f7f;
      end
      inst_type_branch: begin
        ok = f3 >= 0 && s1ok && s2ok && si % 2 == 0 && si >= -4096 && si < 4096;
        w = 32'h63 + ((im / 2048) % 2) * 128 + ((im / 2) % 16) * 256 + f3f + r1 + r2 +
            ((im / 32) % 64) * 32'h2000000 + ((im / 4096) % 2) * 32'h80000000;
      end
      inst_type_store: begin
        ok = f3 >= 0 && s1ok && s2ok && fit12;
        w = 32'h23 + (im % 32) * 128 + f3f + r1 + r2 + ((im / 32) % 128) * 32'h2000000;
      end
      inst_type_load: begin
        ok = f3 >= 0 && dok && s1ok && fit12;
        w = 32'h03 + rdf + f3f + r1 + (im % 4096) * 32'h100000;
      end
      inst_type_fence: begin ok = 1; w = 32'h0FF0000F; end
      default: ;
    endcase
  endfunction
  task automatic send(input logic [31:0] t, f, d, s1, s2, im);
    in_inst_type = t; in_funct = f; in_rd = d; in_rs1 = s1; in_rs2 = s2; in_imm = im;
    in_valid = 1;
    for (int k = 0; k < 20 && !in_ready; k++) begin @(posedge clk); #1; end
    if (!in_ready) begin
      cmp++; bad++;
      $display("FAIL send_timeout: in_ready got %b want 1 within 20 cycles", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 0;
  endtask
  task automatic test_reset;
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    cmp++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    cmp++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    cmp++; if (out_inst !== 32'h0) begin bad++; $display("FAIL reset_out_inst: got %h want 0", out_inst); end
    cmp++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
    cmp++; if (err_count !== 8'h0) begin bad++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
    rst = 1;
    #1;
    cmp++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
  endtask
  task automatic test_vectors;
    logic [31:0] vt [8] = '{inst_type_int_imm, inst_type_int_imm, inst_type_int_reg, inst_type_jal,
                            inst_type_branch, inst_type_store, inst_type_fence, inst_type_imm};
    logic [31:0] vf [8] = '{funct_add, funct_sra, funct_sub, funct_add, funct_eq, funct_mem_word,
                            funct_add, funct_add};
    logic [31:0] vd [8] = '{1, 3, 5, 1, 0, 0, 7, 1};
    logic [31:0] v1 [8] = '{0, 2, 6, 0, 1, 1, 7, 0};
    logic [31:0] v2 [8] = '{0, 0, 7, 0, 2, 2, 7, 0};
    logic [31:0] vi [8] = '{5, 4, 0, 32'hFFFFFFFC, 8, 12, 99, 32'h12345000};
    logic [31:0] ve [8] = '{32'h00500093, 32'h40415193, 32'h407302B3, 32'hFFDFF0EF,
                            32'h00208463, 32'h0020A623, 32'h0FF0000F, 32'h123450B7};
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      send(vt[i], vf[i], vd[i], v1[i], v2[i], vi[i]);
      cmp++;
      if (out_valid !== 1'b1 || out_inst !== ve[i]) begin
        bad++; $display("FAIL vector%0d: got valid=%b inst=%h want valid=1 inst=%h", i, out_valid, out_inst, ve[i]);
      end
      @(posedge clk); #1;
      cmp++; if (out_valid !== 1'b0) begin bad++; $display("FAIL vector%0d_pop: out_valid got %b want 0", i, out_valid); end
    end
  endtask
  task automatic test_illegal;
    out_ready = 1;
    send(inst_type_branch, funct_eq, 0, 1, 2, 7);
    cmp++; if (err !== 1'b1) begin bad++; $display("FAIL illegal_branch_err: got %b want 1", err); end
    cmp++; if (out_valid !== 1'b0) begin bad++; $display("FAIL illegal_branch_valid: got %b want 0", out_valid); end
    send(inst_type_int_imm, funct_sub, 5, 6, 0, 1);
    cmp++; if (err !== 1'b1) begin bad++; $display("FAIL illegal_sub_err: got %b want 1", err); end
    cmp++; if (err_count !== 8'd2) begin bad++; $display("FAIL illegal_count: got %0d want 2", err_count); end
    @(posedge clk); #1;
    cmp++; if (err !== 1'b0) begin bad++; $display("FAIL illegal_err_pulse: got %b want 0", err); end
    cmp++; if (out_valid !== 1'b0) begin bad++; $display("FAIL illegal_fifo_empty: got %b want 0", out_valid); end
  endtask
  task automatic test_back_to_back;
    out_ready = 0;
    send(inst_type_int_imm, funct_add, 1, 0, 0, 5);
    send(inst_type_int_reg, funct_sub, 5, 6, 7, 0);
    in_inst_type = inst_type_branch; in_funct = funct_eq; in_rd = 0; in_rs1 = 1; in_rs2 = 2; in_imm = 8;
    in_valid = 1;
    #1;
    cmp++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_full: in_ready got %b want 0", in_ready); end
    @(posedge clk); #1;
    cmp++; if (out_inst !== 32'h00500093) begin bad++; $display("FAIL b2b_stall: got %h want 00500093", out_inst); end
    out_ready = 1;
    @(posedge clk); #1;
    cmp++; if (out_inst !== 32'h407302B3 || in_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_second: got inst=%h ready=%b want 407302b3 ready=1", out_inst, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 0;
    cmp++; if (out_inst !== 32'h00208463 || out_valid !== 1'b1) begin
      bad++; $display("FAIL b2b_third: got inst=%h valid=%b want 00208463 valid=1", out_inst, out_valid);
    end
    @(posedge clk); #1;
    cmp++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain: out_valid got %b want 0", out_valid); end
  endtask
  task automatic test_flush;
    out_ready = 0;
    send(inst_type_load, funct_mem_byteu, 3, 4, 0, 32'hFFFFF800);
    send(inst_type_auipc, funct_add, 2, 0, 0, 32'hFFFFF000);
    cmp++; if (out_valid !== 1'b1) begin bad++; $display("FAIL flush_pre: out_valid got %b want 1", out_valid); end
    flush = 1; out_ready = 1; in_valid = 1;
    #1;
    cmp++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
    cmp++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
    cmp++; if (err_count !== 8'd2) begin bad++; $display("FAIL flush_err_count: got %0d want 2", err_count); end
    @(posedge clk); #1;
    cmp++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_no_accept: out_valid got %b want 0", out_valid); end
  endtask
  task automatic test_random;
    logic [31:0] q[$];
    logic [31:0] w;
    bit ok, acc, popf, exp_err;
    int ecnt;
    ecnt = 2; exp_err = 0; ok = 0;
    for (int c = 0; c < 400; c++) begin
      in_inst_type = $urandom_range(0, 10);
      in_funct = $urandom_range(0, 21);
      in_rd = $urandom_range(0, 19) == 0 ? 32 + $urandom_range(0, 5) : $urandom_range(0, 31);
      in_rs1 = $urandom_range(0, 19) == 0 ? 32 + $urandom_range(0, 5) : $urandom_range(0, 31);
      in_rs2 = $urandom_range(0, 19) == 0 ? 32 + $urandom_range(0, 5) : $urandom_range(0, 31);
      case ($urandom_range(0, 4))
        0: in_imm = $urandom_range(0, 40);
        1: in_imm = 32'($urandom_range(0, 8000)) - 32'd4000;
        2: in_imm = $urandom;
        3: in_imm = $urandom & 32'hFFFFF000;
        default: in_imm = (32'($urandom_range(0, 2097151)) - 32'd1048576) & ~32'd1;
      endcase
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      #1;
      cmp++; if (out_valid !== (q.size() > 0)) begin bad++; $display("FAIL rnd_out_valid c%0d: got %b want %b", c, out_valid, q.size() > 0); end
      cmp++; if (in_ready !== (q.size() < 2)) begin bad++; $display("FAIL rnd_in_ready c%0d: got %b want %b", c, in_ready, q.size() < 2); end
      if (q.size() > 0) begin
        cmp++; if (out_inst !== q[0]) begin bad++; $display("FAIL rnd_out_inst c%0d: got %h want %h", c, out_inst, q[0]); end
      end
      cmp++; if (err !== exp_err) begin bad++; $display("FAIL rnd_err c%0d: got %b want %b", c, err, exp_err); end
      cmp++; if (err_count !== 8'(ecnt)) begin bad++; $display("FAIL rnd_err_count c%0d: got %0d want %0d", c, err_count, ecnt); end
      acc = in_valid && in_ready;
      popf = out_valid && out_ready;
      if (acc) ref_encode(in_inst_type, in_funct, in_rd, in_rs1, in_rs2, in_imm, ok, w);
      @(posedge clk); #1;
      if (popf && q.size() > 0) void'(q.pop_front());
      if (acc && ok) q.push_back(w);
      exp_err = acc && !ok;
      if (exp_err && ecnt < 255) ecnt++;
    end
    in_valid = 0;
  endtask
  task automatic test_reset_mid;
    out_ready = 1;
    repeat (4) @(posedge clk);
    #1;
    out_ready = 0;
    send(inst_type_jalr, funct_add, 1, 2, 0, 32'hFFFFFFF0);
    send(inst_type_store, funct_mem_byteu, 0, 1, 2, 4);
    cmp++; if (out_valid !== 1'b1 || err !== 1'b1) begin
      bad++; $display("FAIL midrst_pre: got valid=%b err=%b want 1 1", out_valid, err);
    end
    rst = 0;
    #1;
    cmp++; if (out_valid !== 1'b0 || out_inst !== 32'h0) begin
      bad++; $display("FAIL midrst_out: got valid=%b inst=%h want 0 0", out_valid, out_inst);
    end
    cmp++; if (err !== 1'b0 || err_count !== 8'h0 || in_ready !== 1'b0) begin
      bad++; $display("FAIL midrst_ctl: got err=%b cnt=%0d ready=%b want 0 0 0", err, err_count, in_ready);
    end
    @(negedge clk);
    rst = 1;
    out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        bad++; $display("FAIL midrst_after%0d: got valid=%b ready=%b want 0 1", k, out_valid, in_ready);
      end
    end
  endtask
  initial begin
    test_reset;
    test_vectors;
    test_illegal;
    test_back_to_back;
    test_flush;
    test_random;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
